// File: rtl/mem_channel_scheduler.sv
// Round-robin scheduler sharing NUM_CHANNELS memory channels among NUM_CONSUMERS requesters.
// Define MEM_SCHED_WRITE_EN to build the write path (data memory); leave it undefined for read-only program memory.
module mem_channel_scheduler #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        READ_RELAY
`ifdef MEM_SCHED_WRITE_EN
        , WRITE_WAIT,
        WRITE_RELAY
`endif
    } state_t;

    state_t                                  state_q [NUM_CHANNELS];
    state_t                                  state_n [NUM_CHANNELS];
    logic [IDX_W-1:0]                        idx_q   [NUM_CHANNELS];
    logic [IDX_W-1:0]                        idx_n   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                claimed_q, claimed_n;
    logic [NUM_CONSUMERS-1:0]                claim_arb, claim_clr;
    logic [IDX_W-1:0]                        rr_ptr, rr_ptr_n;
    logic [NUM_CONSUMERS-1:0]                rd_ready_n;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_n;
    logic [NUM_CHANNELS-1:0]                 mrv_n;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_n;
    logic [NUM_CONSUMERS-1:0]                write_req;
    logic                                    found;
    int                                      grant;
    int                                      cand;

`ifdef MEM_SCHED_WRITE_EN
    logic [NUM_CONSUMERS-1:0]                wr_ready_n;
    logic [NUM_CHANNELS-1:0]                 mwv_n;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mwa_n;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_n;

    assign write_req = consumer_write_valid;
`else
    logic unused_write_inputs;

    // Program-memory build: write requests are invisible to arbitration and write outputs stay low.
    assign write_req            = '0;
    assign consumer_write_ready = '0;
    assign mem_write_valid      = '0;
    assign mem_write_address    = '0;
    assign mem_write_data       = '0;
    assign unused_write_inputs  = ^{consumer_write_valid, consumer_write_address,
                                    consumer_write_data, mem_write_ready};
`endif

    always_comb begin
        // NOTE: every variable written here gets its hold value first, so no path can infer a latch.
        claim_arb  = claimed_q;
        claim_clr  = '0;
        rr_ptr_n   = rr_ptr;
        rd_ready_n = consumer_read_ready;
        rd_data_n  = consumer_read_data;
        mrv_n      = mem_read_valid;
        mra_n      = mem_read_address;
        found      = 1'b0;
        grant      = 0;
        cand       = 0;
`ifdef MEM_SCHED_WRITE_EN
        wr_ready_n = consumer_write_ready;
        mwv_n      = mem_write_valid;
        mwa_n      = mem_write_address;
        mwd_n      = mem_write_data;
`endif
        // Ascending channel order: claim_arb carries grants made by lower channels this cycle.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_n[ch] = state_q[ch];
            idx_n[ch]   = idx_q[ch];
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    grant = 0;
                    for (int j = 0; j < NUM_CONSUMERS; j++) begin
                        cand = (int'(rr_ptr) + j) % NUM_CONSUMERS;
                        if (!found && !claim_arb[cand] &&
                            (consumer_read_valid[cand] || write_req[cand])) begin
                            found = 1'b1;
                            grant = cand;
                        end
                    end
                    if (found) begin
                        claim_arb[grant] = 1'b1;
                        idx_n[ch]        = IDX_W'(grant);
                        rr_ptr_n         = IDX_W'((grant + 1) % NUM_CONSUMERS);
                        if (consumer_read_valid[grant]) begin
                            state_n[ch] = READ_WAIT;
                            mrv_n[ch]   = 1'b1;
                            mra_n[ch]   = consumer_read_address[grant];
                        end
`ifdef MEM_SCHED_WRITE_EN
                        else begin
                            state_n[ch] = WRITE_WAIT;
                            mwv_n[ch]   = 1'b1;
                            mwa_n[ch]   = consumer_write_address[grant];
                            mwd_n[ch]   = consumer_write_data[grant];
                        end
`endif
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        mrv_n[ch]              = 1'b0;
                        rd_data_n[idx_q[ch]]   = mem_read_data[ch];
                        rd_ready_n[idx_q[ch]]  = 1'b1;
                        state_n[ch]            = READ_RELAY;
                    end
                end
                READ_RELAY: begin
                    if (!consumer_read_valid[idx_q[ch]]) begin
                        rd_ready_n[idx_q[ch]] = 1'b0;
                        claim_clr[idx_q[ch]]  = 1'b1;
                        state_n[ch]           = IDLE;
                    end
                end
`ifdef MEM_SCHED_WRITE_EN
                WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        mwv_n[ch]             = 1'b0;
                        wr_ready_n[idx_q[ch]] = 1'b1;
                        state_n[ch]           = WRITE_RELAY;
                    end
                end
                WRITE_RELAY: begin
                    if (!consumer_write_valid[idx_q[ch]]) begin
                        wr_ready_n[idx_q[ch]] = 1'b0;
                        claim_clr[idx_q[ch]]  = 1'b1;
                        state_n[ch]           = IDLE;
                    end
                end
`endif
                default: state_n[ch] = IDLE;
            endcase
        end
        // Releases take effect next cycle, so a freed consumer is not re-granted in its release cycle.
        claimed_n = claim_arb & ~claim_clr;
    end

    // NOTE: read data is reset along with everything else because all outputs must read 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                idx_q[ch]   <= '0;
            end
            claimed_q           <= '0;
            rr_ptr              <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
`ifdef MEM_SCHED_WRITE_EN
            consumer_write_ready <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_n[ch];
                idx_q[ch]   <= idx_n[ch];
            end
            claimed_q           <= claimed_n;
            rr_ptr              <= rr_ptr_n;
            consumer_read_ready <= rd_ready_n;
            consumer_read_data  <= rd_data_n;
            mem_read_valid      <= mrv_n;
            mem_read_address    <= mra_n;
`ifdef MEM_SCHED_WRITE_EN
            consumer_write_ready <= wr_ready_n;
            mem_write_valid      <= mwv_n;
            mem_write_address    <= mwa_n;
            mem_write_data       <= mwd_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_channel_scheduler.sv
// Self-checking bench for mem_channel_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_mem_channel_scheduler;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 4;
    localparam int NCH = 2;
`ifdef MEM_SCHED_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    localparam int FREE    = 0;
    localparam int RD_MEM  = 1;
    localparam int WR_MEM  = 2;
    localparam int RD_HOLD = 3;
    localparam int WR_HOLD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [NC-1:0]          rv, wv, crr, cwr;
    logic [NC-1:0][AB-1:0]  ra, wa;
    logic [NC-1:0][DB-1:0]  wd, crd;
    logic [NCH-1:0]         mrv, mrr, mwv, mwr;
    logic [NCH-1:0][AB-1:0] mra, mwa;
    logic [NCH-1:0][DB-1:0] mrd, mwd;

    mem_channel_scheduler #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (rv),
        .consumer_read_address (ra),
        .consumer_read_ready   (crr),
        .consumer_read_data    (crd),
        .consumer_write_valid  (wv),
        .consumer_write_address(wa),
        .consumer_write_data   (wd),
        .consumer_write_ready  (cwr),
        .mem_read_valid        (mrv),
        .mem_read_address      (mra),
        .mem_read_ready        (mrr),
        .mem_read_data         (mrd),
        .mem_write_valid       (mwv),
        .mem_write_address     (mwa),
        .mem_write_data        (mwd),
        .mem_write_ready       (mwr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        mrr = '0; mrd = '0; mwr = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Reference model: per-channel transaction stage, owner and claims, arbitration via an ordered queue.
    int                     m_phase [NCH];
    int                     m_own   [NCH];
    bit                     m_claim [NC];
    int                     m_rr;
    logic [NC-1:0]          e_crr, e_cwr;
    logic [NC-1:0][DB-1:0]  e_crd;
    logic [NCH-1:0]         e_mrv, e_mwv;
    logic [NCH-1:0][AB-1:0] e_mra, e_mwa;
    logic [NCH-1:0][DB-1:0] e_mwd;

    function automatic void model_reset();
        foreach (m_phase[k]) begin m_phase[k] = FREE; m_own[k] = 0; end
        foreach (m_claim[k]) m_claim[k] = 1'b0;
        m_rr = 0;
        e_crr = '0; e_cwr = '0; e_crd = '0;
        e_mrv = '0; e_mwv = '0; e_mra = '0; e_mwa = '0; e_mwd = '0;
    endfunction

    task automatic model_step();
        int order[$];
        bit rel[NC];
        int c;
        int last;
        last = -1;
        foreach (rel[k]) rel[k] = 1'b0;
        for (int j = 0; j < NC; j++) begin
            c = (m_rr + j) % NC;
            if (!m_claim[c] && (rv[c] || (WEN && wv[c]))) order.push_back(c);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            c = m_own[ch];
            case (m_phase[ch])
                FREE: if (order.size() > 0) begin
                    c = order.pop_front();
                    m_claim[c] = 1'b1;
                    m_own[ch]  = c;
                    last       = c;
                    if (rv[c]) begin
                        m_phase[ch] = RD_MEM; e_mrv[ch] = 1'b1; e_mra[ch] = ra[c];
                    end else begin
                        m_phase[ch] = WR_MEM; e_mwv[ch] = 1'b1; e_mwa[ch] = wa[c]; e_mwd[ch] = wd[c];
                    end
                end
                RD_MEM: if (mrr[ch]) begin
                    e_mrv[ch] = 1'b0; e_crd[c] = mrd[ch]; e_crr[c] = 1'b1; m_phase[ch] = RD_HOLD;
                end
                WR_MEM: if (mwr[ch]) begin
                    e_mwv[ch] = 1'b0; e_cwr[c] = 1'b1; m_phase[ch] = WR_HOLD;
                end
                RD_HOLD: if (!rv[c]) begin
                    e_crr[c] = 1'b0; rel[c] = 1'b1; m_phase[ch] = FREE;
                end
                WR_HOLD: if (!wv[c]) begin
                    e_cwr[c] = 1'b0; rel[c] = 1'b1; m_phase[ch] = FREE;
                end
                default: m_phase[ch] = FREE;
            endcase
        end
        if (last >= 0) m_rr = (last + 1) % NC;
        foreach (rel[k]) if (rel[k]) m_claim[k] = 1'b0;
    endtask

    function automatic logic [127:0] pack_dut();
        return 128'({crr, crd, cwr, mrv, mra, mwv, mwa, mwd});
    endfunction

    function automatic logic [127:0] pack_exp();
        return 128'({e_crr, e_crd, e_cwr, e_mrv, e_mra, e_mwv, e_mwa, e_mwd});
    endfunction

    typedef struct {
        logic       rv0;
        logic [7:0] addr0;
        logic       mrr0;
        logic [7:0] mrd0;
        logic [1:0] e_mrv;
        logic [7:0] e_maddr0;
        logic [3:0] e_crr;
        logic [7:0] e_crd0;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Single read with immediate ack, release, then a second read stalled for 5 cycles.
        vecs[0]  = '{1'b1, 8'h12, 1'b0, 8'h00, 2'b01, 8'h12, 4'b0000, 8'h00};
        vecs[1]  = '{1'b1, 8'h12, 1'b1, 8'hA5, 2'b00, 8'h12, 4'b0001, 8'hA5};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 8'h12, 4'b0000, 8'hA5};
        vecs[3]  = '{1'b1, 8'h34, 1'b0, 8'h00, 2'b01, 8'h34, 4'b0000, 8'hA5};
        for (int i = 4; i < 9; i++)
            vecs[i] = '{1'b1, 8'h34, 1'b0, 8'h00, 2'b01, 8'h34, 4'b0000, 8'hA5};
        vecs[9]  = '{1'b1, 8'h34, 1'b1, 8'h3C, 2'b00, 8'h34, 4'b0001, 8'h3C};
        vecs[10] = '{1'b1, 8'h34, 1'b0, 8'h00, 2'b00, 8'h34, 4'b0001, 8'h3C};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 8'h34, 4'b0000, 8'h3C};

        do_reset();
        check("reset_state", pack_dut(), '0);

        for (int i = 0; i < 12; i++) begin
            rv = {3'b000, vecs[i].rv0};
            ra[0] = vecs[i].addr0;
            mrr = {1'b0, vecs[i].mrr0};
            mrd[0] = vecs[i].mrd0;
            tick();
            check($sformatf("vec%0d", i), 128'({mrv, mra[0], crr, crd[0]}),
                  128'({vecs[i].e_mrv, vecs[i].e_maddr0, vecs[i].e_crr, vecs[i].e_crd0}));
        end

        // Contention: four readers, two channels, round-robin fairness.
        do_reset();
        for (int i = 0; i < NC; i++) ra[i] = 8'(8'h40 + i);
        rv = 4'b1111;
        tick();
        check("cont_first_valid", 128'(mrv), 128'(2'b11));
        check("cont_first_addr", 128'(mra), 128'({8'h41, 8'h40}));
        mrr = 2'b11; mrd = {8'hD1, 8'hD0};
        tick();
        check("cont_first_ready", 128'({crr, mrv}), 128'({4'b0011, 2'b00}));
        check("cont_first_data", 128'(crd[1:0]), 128'({8'hD1, 8'hD0}));
        rv = 4'b1100; mrr = 2'b00;
        tick();
        check("cont_release", 128'({crr, mrv}), '0);
        rv = 4'b1111;
        tick();
        check("cont_second_addr", 128'({mrv, mra}), 128'({2'b11, 8'h43, 8'h42}));
        mrr = 2'b11; mrd = {8'hE3, 8'hE2};
        tick();
        check("cont_second_ready", 128'({crr, crd[3:2]}), 128'({4'b1100, 8'hE3, 8'hE2}));
        rv = 4'b0011; mrr = 2'b00;
        tick();
        check("cont_second_release", 128'(crr), '0);
        tick();
        check("cont_wrap_addr", 128'({mrv, mra}), 128'({2'b11, 8'h41, 8'h40}));

        // Reset asserted while channel 0 waits on memory.
        do_reset();
        rv = 4'b0001; ra[0] = 8'h55;
        tick();
        check("rst_pre_grant", 128'({mrv, mra[0]}), 128'({2'b01, 8'h55}));
        #3;
        reset = 1'b0; mrr = 2'b11;
        #1;
        check("rst_async_clear", pack_dut(), '0);
        rv = '0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_no_spurious", 128'({crr, mrv}), '0);
        rv = 4'b0011; ra[0] = 8'h60; ra[1] = 8'h61;
        tick();
        check("rst_rr_from_zero", 128'({crr, mrv, mra}), 128'({4'b0000, 2'b11, 8'h61, 8'h60}));
        tick();
        check("rst_after_ready", 128'(crr), 128'(4'b0011));
        rv = '0; mrr = '0;
        tick();

`ifdef MEM_SCHED_WRITE_EN
        // Same consumer requests read and write together: read first, write after the read relay.
        do_reset();
        rv = 4'b0010; wv = 4'b0010; ra[1] = 8'h21; wa[1] = 8'h31; wd[1] = 8'h77;
        tick();
        check("rw_read_first", 128'({mrv, mwv, mra[0]}), 128'({2'b01, 2'b00, 8'h21}));
        mrr = 2'b01; mrd[0] = 8'h9A;
        tick();
        check("rw_read_done", 128'({crr, crd[1]}), 128'({4'b0010, 8'h9A}));
        rv = '0; mrr = '0;
        tick();
        check("rw_read_release", 128'({crr, mwv}), '0);
        tick();
        check("rw_write_grant", 128'({mwv, mwa[0], mwd[0]}), 128'({2'b01, 8'h31, 8'h77}));
        mwr = 2'b01;
        tick();
        check("rw_write_done", 128'({cwr, mwv}), 128'({4'b0010, 2'b00}));
        wv = '0; mwr = '0;
        tick();
        check("rw_write_release", 128'(cwr), '0);
`else
        // Without the write path, write requests must be ignored entirely.
        do_reset();
        wv = 4'b1111; wa = {8'h13, 8'h12, 8'h11, 8'h10}; wd = {8'hF3, 8'hF2, 8'hF1, 8'hF0}; mwr = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("nowrite_cycle%0d", i), 128'({mwv, cwr, mwa, mwd, mrv, crr}), '0);
        end
        wv = '0; mwr = '0;
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(3) == 0) rv[c] = ~rv[c];
                if ($urandom_range(3) == 0) wv[c] = ~wv[c];
                ra[c] = 8'($urandom);
                wa[c] = 8'($urandom);
                wd[c] = 8'($urandom);
            end
            for (int ch = 0; ch < NCH; ch++) begin
                mrr[ch] = 1'($urandom_range(1));
                mwr[ch] = 1'($urandom_range(1));
                mrd[ch] = 8'($urandom);
            end
            model_step();
            tick();
            check($sformatf("random_cycle%0d", cyc), pack_dut(), pack_exp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
